micro_pipeline_ctrl: RTL and testbench

//  Sequencer for the 3-stage microinstruction pipeline: S1 fetch/decode, S2 and S3 pipeline registers.

---
 rtl/micro_pipeline_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_micro_pipeline_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_pipeline_ctrl.sv
// micro_pipeline_ctrl: sequencer for a 3-stage microinstruction pipeline (S1 fetch/decode, S2, S3).
// Build macro PERF_CNT_EN adds saturating stall/bubble counters; s2_en/s3_en/s2_bubble report the load done at the last edge.
module micro_pipeline_ctrl #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic [3:0]        mir_b_sel,
    input  logic [5:0]        mir_c_mask,
    input  logic [1:0]        mir_jam,
    input  logic [ADDR_W-1:0] mir_next,
    input  logic              alu_n,
    input  logic              alu_z,
    output logic [ADDR_W-1:0] mpc,
    output logic              s2_en,
    output logic              s3_en,
    output logic              s2_bubble,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL,
        ST_BRWAIT,
        ST_DRAIN,
        ST_HALT
    } state_t;

    localparam logic [1:0] JAM_SEQ = 2'b00;
    localparam logic [1:0] JAM_N   = 2'b01;
    localparam logic [1:0] JAM_Z   = 2'b10;
    localparam logic [1:0] JAM_UNC = 2'b11;

    state_t             state_reg;
    logic [ADDR_W-1:0]  mpc_reg;
    logic [ADDR_W-1:0]  br_target_reg;
    logic [1:0]         br_cnt_reg;
    logic [5:0]         sh2_mask_reg;
    logic [5:0]         sh3_mask_reg;
    logic [1:0]         sh2_jam_reg;
    logic [1:0]         sh3_jam_reg;
    logic               s2_en_reg;
    logic               s3_en_reg;
    logic               s2_bubble_reg;
    logic               busy_reg;

    logic               is_active;
    logic               is_fetching;
    logic               hazard;
    logic               bubble_now;
    logic               taken;
    logic [5:0]         inflight_mask;
    logic [5:0]         hazard_hit;

    // A register is "in flight" while either downstream stage still intends to write it.
    assign inflight_mask = sh2_mask_reg | sh3_mask_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_hazard
            assign hazard_hit[gi] = (mir_b_sel == 4'(gi)) && inflight_mask[gi];
        end
    endgenerate

    assign hazard = |hazard_hit;

    assign is_active = (state_reg == ST_RUN) || (state_reg == ST_STALL) ||
                       (state_reg == ST_BRWAIT) || (state_reg == ST_DRAIN);

    assign is_fetching = ((state_reg == ST_RUN) || (state_reg == ST_STALL)) && !halt_req;

    // Anything other than a clean S1 issue pushes a NOP into S2.
    assign bubble_now = is_active && !(is_fetching && !hazard);

    // The branch sits in S3 when it resolves, so its jam code comes from the S3 shadow.
    assign taken = ((sh3_jam_reg == JAM_N) && alu_n) ||
                   ((sh3_jam_reg == JAM_Z) && alu_z);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mpc_reg       <= RESET_ADDR;
            br_target_reg <= '0;
            br_cnt_reg    <= 2'd0;
            sh2_mask_reg  <= '0;
            sh3_mask_reg  <= '0;
            sh2_jam_reg   <= JAM_SEQ;
            sh3_jam_reg   <= JAM_SEQ;
            s2_en_reg     <= 1'b0;
            s3_en_reg     <= 1'b0;
            s2_bubble_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            s2_en_reg     <= is_active;
            s3_en_reg     <= is_active;
            s2_bubble_reg <= bubble_now;

            if (is_active) begin
                sh3_mask_reg <= sh2_mask_reg;
                sh3_jam_reg  <= sh2_jam_reg;
                sh2_mask_reg <= bubble_now ? 6'd0 : mir_c_mask;
                sh2_jam_reg  <= bubble_now ? JAM_SEQ : mir_jam;
            end

            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_reg    <= ST_RUN;
                        mpc_reg      <= RESET_ADDR;
                        busy_reg     <= 1'b1;
                        sh2_mask_reg <= '0;
                        sh3_mask_reg <= '0;
                        sh2_jam_reg  <= JAM_SEQ;
                        sh3_jam_reg  <= JAM_SEQ;
                    end
                end

                ST_RUN, ST_STALL: begin
                    if (halt_req) begin
                        state_reg <= ST_DRAIN;
                    end else if (hazard) begin
                        state_reg <= ST_STALL;
                    end else begin
                        state_reg <= ST_RUN;
                        case (mir_jam)
                            JAM_UNC: mpc_reg <= mir_next;
                            JAM_N, JAM_Z: begin
                                state_reg     <= ST_BRWAIT;
                                br_cnt_reg    <= 2'd2;
                                br_target_reg <= mir_next;
                            end
                            default: mpc_reg <= mpc_reg + ADDR_W'(1);
                        endcase
                    end
                end

                ST_BRWAIT: begin
                    if (halt_req) begin
                        // The in-flight branch is dropped; its target is never used.
                        state_reg <= ST_DRAIN;
                    end else if (br_cnt_reg == 2'd1) begin
                        state_reg <= ST_RUN;
                        mpc_reg   <= taken ? br_target_reg : mpc_reg + ADDR_W'(1);
                    end else begin
                        br_cnt_reg <= br_cnt_reg - 2'd1;
                    end
                end

                ST_DRAIN: begin
                    state_reg <= ST_HALT;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mpc       = mpc_reg;
    assign s2_en     = s2_en_reg;
    assign s3_en     = s3_en_reg;
    assign s2_bubble = s2_bubble_reg;
    assign busy      = busy_reg;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] bubble_cnt_reg;
    logic             hazard_stall;
    logic             cnt_clr;

    assign hazard_stall = is_fetching && hazard;
    assign cnt_clr      = start && ((state_reg == ST_IDLE) || (state_reg == ST_HALT));

    always_ff @(posedge clock) begin
        if (reset || cnt_clr) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (hazard_stall && !(&stall_cnt_reg)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (bubble_now && !(&bubble_cnt_reg)) begin
                bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign bubble_cnt   = bubble_cnt_reg;
`else
    assign stall_cycles = '0;
    assign bubble_cnt   = '0;
`endif

endmodule

// File: tb/tb_micro_pipeline_ctrl.sv
// Self-checking bench for micro_pipeline_ctrl: directed scenarios plus randomized programs
// checked against a pipeline-contents reference model.
module tb_micro_pipeline_ctrl;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_WAIT  = 2;
    localparam int M_DRAIN = 3;
    localparam int M_HALT  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic [3:0]  mir_b_sel = 4'd6;
    logic [5:0]  mir_c_mask = 6'd0;
    logic [1:0]  mir_jam = 2'd0;
    logic [7:0]  mir_next = 8'd0;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic [7:0]  mpc;
    logic        s2_en;
    logic        s3_en;
    logic        s2_bubble;
    logic        busy;
    logic [15:0] stall_cycles;
    logic [15:0] bubble_cnt;

    micro_pipeline_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .halt_req     (halt_req),
        .mir_b_sel    (mir_b_sel),
        .mir_c_mask   (mir_c_mask),
        .mir_jam      (mir_jam),
        .mir_next     (mir_next),
        .alu_n        (alu_n),
        .alu_z        (alu_z),
        .mpc          (mpc),
        .s2_en        (s2_en),
        .s3_en        (s3_en),
        .s2_bubble    (s2_bubble),
        .busy         (busy),
        .stall_cycles (stall_cycles),
        .bubble_cnt   (bubble_cnt)
    );

    always #5 clock = ~clock;

    // Control store seen by S1, addressed by the model's own mpc.
    logic [3:0] p_bsel [256];
    logic [5:0] p_mask [256];
    logic [1:0] p_jam  [256];
    logic [7:0] p_next [256];

    // Reference model: which instructions occupy S2/S3, plus the sequencer mode.
    typedef struct packed {
        logic [5:0] mask;
        logic [1:0] jam;
        logic [7:0] target;
    } slot_t;

    int         m_mode;
    logic [7:0] m_mpc;
    slot_t      m_s2;
    slot_t      m_s3;
    bit         m_en;
    bit         m_bub;
    int         m_stalls;
    int         m_bubbles;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic model_edge();
        slot_t      fetched;
        logic [5:0] pending;
        bit         hz;
        bit         bub;
        bit         tk;
        fetched = '{mask: mir_c_mask, jam: mir_jam, target: mir_next};
        if (reset) begin
            m_mode = M_IDLE; m_mpc = 8'd0; m_s2 = '0; m_s3 = '0;
            m_en = 0; m_bub = 0; m_stalls = 0; m_bubbles = 0;
            return;
        end
        if (m_mode == M_IDLE || m_mode == M_HALT) begin
            m_en = 0; m_bub = 0;
            if (start) begin
                m_mode = M_RUN; m_mpc = 8'd0; m_s2 = '0; m_s3 = '0;
                m_stalls = 0; m_bubbles = 0;
            end
            return;
        end
        m_en = 1;
        pending = m_s2.mask | m_s3.mask;
        hz = 0;
        for (int r = 0; r < 6; r++) begin
            if (int'(mir_b_sel) == r && pending[r]) hz = 1;
        end
        bub = 1;
        if (m_mode == M_DRAIN) begin
            m_mode = M_HALT;
        end else if (halt_req) begin
            m_mode = M_DRAIN;
        end else if (m_mode == M_WAIT) begin
            if (m_s3.jam == 2'b01 || m_s3.jam == 2'b10) begin
                tk = (m_s3.jam == 2'b01 && alu_n) || (m_s3.jam == 2'b10 && alu_z);
                m_mpc = tk ? m_s3.target : m_mpc + 8'd1;
                m_mode = M_RUN;
            end
        end else if (hz) begin
            if (m_stalls < 65535) m_stalls++;
        end else begin
            bub = 0;
            if (mir_jam == 2'b11) m_mpc = mir_next;
            else if (mir_jam == 2'b00) m_mpc = m_mpc + 8'd1;
            else m_mode = M_WAIT;
        end
        m_s3 = m_s2;
        m_s2 = bub ? slot_t'(0) : fetched;
        m_bub = bub;
        if (bub && m_bubbles < 65535) m_bubbles++;
    endtask

    task automatic step();
        mir_b_sel  = p_bsel[m_mpc];
        mir_c_mask = p_mask[m_mpc];
        mir_jam    = p_jam[m_mpc];
        mir_next   = p_next[m_mpc];
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_seq_all();
        for (int a = 0; a < 256; a++) begin
            p_bsel[a] = 4'd6; p_mask[a] = 6'd0; p_jam[a] = 2'b00; p_next[a] = 8'd0;
        end
    endtask

    task automatic do_reset();
        reset = 1; start = 0; halt_req = 0;
        step();
        reset = 0;
    endtask

    task automatic do_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        n_cmp += 7;
        if (mpc !== 8'd0)        begin n_fail++; $display("FAIL reset_mpc: got %0h expected 0", mpc); end
        if (s2_en !== 1'b0)      begin n_fail++; $display("FAIL reset_s2_en: got %b expected 0", s2_en); end
        if (s3_en !== 1'b0)      begin n_fail++; $display("FAIL reset_s3_en: got %b expected 0", s3_en); end
        if (s2_bubble !== 1'b0)  begin n_fail++; $display("FAIL reset_bubble: got %b expected 0", s2_bubble); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (stall_cycles !== 0)  begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cycles); end
        if (bubble_cnt !== 0)    begin n_fail++; $display("FAIL reset_bubble_cnt: got %0d expected 0", bubble_cnt); end
        reset = 0;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_without_start: busy got %b expected 0", busy); end
        $display("test_reset: mpc=%0h busy=%b", mpc, busy);
    endtask

    task automatic test_sequential();
        set_seq_all();
        do_reset();
        do_start();
        n_cmp += 2;
        if (mpc !== 8'd0) begin n_fail++; $display("FAIL seq_start_mpc: got %0h expected 0", mpc); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL seq_start_busy: got %b expected 1", busy); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp += 3;
            if (mpc !== 8'(i)) begin n_fail++; $display("FAIL seq_mpc: got %0h expected %0h", mpc, i); end
            if (s2_bubble !== 1'b0) begin n_fail++; $display("FAIL seq_bubble: got %b expected 0", s2_bubble); end
            if (s2_en !== 1'b1 || s3_en !== 1'b1) begin
                n_fail++; $display("FAIL seq_load_en: got s2_en=%b s3_en=%b expected 1/1", s2_en, s3_en);
            end
            $display("test_sequential: step %0d mpc=%0h bubble=%b", i, mpc, s2_bubble);
        end
    endtask

    task automatic test_hazard();
        int exp_mpc [4] = '{1, 1, 1, 2};
        bit exp_bub [4] = '{0, 1, 1, 0};
        set_seq_all();
        p_mask[0] = 6'b000100;
        p_bsel[1] = 4'd2;
        do_reset();
        do_start();
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp += 2;
            if (mpc !== 8'(exp_mpc[i])) begin n_fail++; $display("FAIL hazard_mpc[%0d]: got %0h expected %0h", i, mpc, exp_mpc[i]); end
            if (s2_bubble !== exp_bub[i]) begin n_fail++; $display("FAIL hazard_bubble[%0d]: got %b expected %b", i, s2_bubble, exp_bub[i]); end
            $display("test_hazard: cycle %0d mpc=%0h bubble=%b", i, mpc, s2_bubble);
        end
        n_cmp += 2;
        if (stall_cycles !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL hazard_stall_cnt: got %0d expected %0d", stall_cycles, PERF ? 2 : 0); end
        if (bubble_cnt !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL hazard_bubble_cnt: got %0d expected %0d", bubble_cnt, PERF ? 2 : 0); end
    endtask

    task automatic test_branch(input bit z_flag);
        logic [7:0] exp_mpc [3];
        bit         exp_bub [3] = '{0, 1, 1};
        exp_mpc[0] = 8'h05; exp_mpc[1] = 8'h05; exp_mpc[2] = z_flag ? 8'h40 : 8'h06;
        set_seq_all();
        p_jam[5] = 2'b10; p_next[5] = 8'h40;
        alu_z = z_flag; alu_n = ~z_flag;
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (mpc !== 8'h05) begin n_fail++; $display("FAIL branch_reach_mpc: got %0h expected 5", mpc); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp += 2;
            if (mpc !== exp_mpc[i]) begin n_fail++; $display("FAIL branch_mpc[%0d] z=%b: got %0h expected %0h", i, z_flag, mpc, exp_mpc[i]); end
            if (s2_bubble !== exp_bub[i]) begin n_fail++; $display("FAIL branch_bubble[%0d] z=%b: got %b expected %b", i, z_flag, s2_bubble, exp_bub[i]); end
        end
        n_cmp++;
        if (bubble_cnt !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL branch_bubble_cnt: got %0d expected %0d", bubble_cnt, PERF ? 2 : 0); end
        $display("test_branch: alu_z=%b resolved mpc=%0h", z_flag, mpc);
        alu_z = 0; alu_n = 0;
    endtask

    task automatic test_jump_wrap();
        set_seq_all();
        p_jam[0] = 2'b11; p_next[0] = 8'hFF;
        p_jam[8'hFF] = 2'b11; p_next[8'hFF] = 8'h10;
        do_reset();
        do_start();
        step();
        step();
        n_cmp += 2;
        if (mpc !== 8'h10) begin n_fail++; $display("FAIL jump_mpc: got %0h expected 10", mpc); end
        if (s2_bubble !== 1'b0) begin n_fail++; $display("FAIL jump_bubble: got %b expected 0", s2_bubble); end
        $display("test_jump_wrap: jump from ff mpc=%0h", mpc);
        p_jam[8'hFF] = 2'b00;
        do_reset();
        do_start();
        step();
        n_cmp++;
        if (mpc !== 8'hFF) begin n_fail++; $display("FAIL wrap_reach_mpc: got %0h expected ff", mpc); end
        step();
        n_cmp += 2;
        if (mpc !== 8'h00) begin n_fail++; $display("FAIL wrap_mpc: got %0h expected 0", mpc); end
        if (s2_bubble !== 1'b0) begin n_fail++; $display("FAIL wrap_bubble: got %b expected 0", s2_bubble); end
        $display("test_jump_wrap: seq from ff mpc=%0h", mpc);
    endtask

    task automatic test_halt_drain();
        set_seq_all();
        p_jam[1] = 2'b01; p_next[1] = 8'h20;
        alu_n = 1;
        do_reset();
        do_start();
        step();
        step();
        halt_req = 1;
        step();
        halt_req = 0;
        n_cmp += 2;
        if (s2_bubble !== 1'b1) begin n_fail++; $display("FAIL drain1_bubble: got %b expected 1", s2_bubble); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL drain1_busy: got %b expected 1", busy); end
        step();
        n_cmp += 2;
        if (s2_bubble !== 1'b1) begin n_fail++; $display("FAIL drain2_bubble: got %b expected 1", s2_bubble); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy: got %b expected 0", busy); end
        step();
        n_cmp += 3;
        if (mpc !== 8'h01) begin n_fail++; $display("FAIL halt_branch_discarded: mpc got %0h expected 1", mpc); end
        if (s2_en !== 1'b0 || s3_en !== 1'b0) begin n_fail++; $display("FAIL halt_load_en: got s2_en=%b s3_en=%b expected 0/0", s2_en, s3_en); end
        if (bubble_cnt !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL drain_bubble_cnt: got %0d expected %0d", bubble_cnt, PERF ? 2 : 0); end
        $display("test_halt_drain: halted mpc=%0h busy=%b", mpc, busy);
        alu_n = 0;
        do_start();
        n_cmp += 3;
        if (mpc !== 8'h00) begin n_fail++; $display("FAIL restart_mpc: got %0h expected 0", mpc); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b expected 1", busy); end
        if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL restart_cnt_clear: got %0d expected 0", bubble_cnt); end
        $display("test_halt_drain: restarted mpc=%0h busy=%b", mpc, busy);
    endtask

    task automatic test_reset_in_stall();
        set_seq_all();
        p_mask[0] = 6'b000100;
        p_bsel[1] = 4'd2;
        do_reset();
        do_start();
        step();
        step();
        n_cmp++;
        if (s2_bubble !== 1'b1) begin n_fail++; $display("FAIL stall_entry_bubble: got %b expected 1", s2_bubble); end
        reset = 1;
        step();
        reset = 0;
        n_cmp += 5;
        if (mpc !== 8'd0) begin n_fail++; $display("FAIL rst_stall_mpc: got %0h expected 0", mpc); end
        if (s2_en !== 1'b0 || s3_en !== 1'b0) begin n_fail++; $display("FAIL rst_stall_load_en: got %b/%b expected 0/0", s2_en, s3_en); end
        if (s2_bubble !== 1'b0) begin n_fail++; $display("FAIL rst_stall_bubble: got %b expected 0", s2_bubble); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_stall_busy: got %b expected 0", busy); end
        if (stall_cycles !== 16'd0 || bubble_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_stall_counters: got %0d/%0d expected 0/0", stall_cycles, bubble_cnt);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || s2_en !== 1'b0) begin n_fail++; $display("FAIL rst_stall_idle: got busy=%b s2_en=%b expected 0/0", busy, s2_en); end
        $display("test_reset_in_stall: mpc=%0h busy=%b", mpc, busy);
    endtask

    task automatic test_random();
        int runs = 0;
        for (int a = 0; a < 256; a++) begin
            p_bsel[a] = 4'($urandom_range(0, 9));
            p_mask[a] = 6'($urandom & $urandom);
            case ($urandom_range(0, 5))
                0, 1, 2: p_jam[a] = 2'b00;
                3:       p_jam[a] = 2'b01;
                4:       p_jam[a] = 2'b10;
                default: p_jam[a] = 2'b11;
            endcase
            p_next[a] = 8'($urandom);
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            if (m_mode == M_IDLE || m_mode == M_HALT) start = ($urandom_range(0, 3) == 0);
            else start = ($urandom_range(0, 49) == 0);
            halt_req = ($urandom_range(0, 79) == 0);
            alu_n = 1'($urandom);
            alu_z = 1'($urandom);
            if (start && !reset && (m_mode == M_IDLE || m_mode == M_HALT)) begin
                runs++;
                $display("test_random: run %0d starts at cycle %0d", runs, c);
            end
            step();
            n_cmp += 7;
            if (mpc !== m_mpc) begin n_fail++; $display("FAIL rnd_mpc c=%0d: got %0h expected %0h", c, mpc, m_mpc); end
            if (s2_en !== m_en) begin n_fail++; $display("FAIL rnd_s2_en c=%0d: got %b expected %b", c, s2_en, m_en); end
            if (s3_en !== m_en) begin n_fail++; $display("FAIL rnd_s3_en c=%0d: got %b expected %b", c, s3_en, m_en); end
            if (s2_bubble !== m_bub) begin n_fail++; $display("FAIL rnd_bubble c=%0d: got %b expected %b", c, s2_bubble, m_bub); end
            if (busy !== (m_mode == M_RUN || m_mode == M_WAIT || m_mode == M_DRAIN)) begin
                n_fail++; $display("FAIL rnd_busy c=%0d: got %b mode %0d", c, busy, m_mode);
            end
            if (stall_cycles !== (PERF ? 16'(m_stalls) : 16'd0)) begin
                n_fail++; $display("FAIL rnd_stall_cnt c=%0d: got %0d expected %0d", c, stall_cycles, PERF ? m_stalls : 0);
            end
            if (bubble_cnt !== (PERF ? 16'(m_bubbles) : 16'd0)) begin
                n_fail++; $display("FAIL rnd_bubble_cnt c=%0d: got %0d expected %0d", c, bubble_cnt, PERF ? m_bubbles : 0);
            end
        end
        reset = 0; start = 0; halt_req = 0;
    endtask

    initial begin
        set_seq_all();
        m_mode = M_IDLE; m_mpc = 8'd0; m_s2 = '0; m_s3 = '0;
        m_en = 0; m_bub = 0; m_stalls = 0; m_bubbles = 0;
        test_reset();
        test_sequential();
        test_hazard();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jump_wrap();
        test_halt_drain();
        test_reset_in_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
